mcpu_mmio_port: RTL and testbench

MCPU_MMIO_PORT -- requirements
Module: mcpu_mmio_port

---
 rtl/mcpu_mmio_port.sv | 141 ++++++++++++++
 tb/tb_mcpu_mmio_port.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_mmio_port.sv
// Memory-mapped I/O port for a small core: OUT/IN registers, a TX FIFO, STATUS and a cycle counter.
// One request is in flight at a time; the response is registered and presented the cycle after acceptance.
module mcpu_mmio_port #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [31:0] memoutput,
  input  logic [31:0] meminput,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        dbg_state
);

  localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  localparam logic [2:0] ADDR_OUT    = 3'd0;
  localparam logic [2:0] ADDR_IN     = 3'd1;
  localparam logic [2:0] ADDR_TXPUSH = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_CYCLE  = 3'd4;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid and payload are held until that edge.
  state_t      state, state_next;
  logic        accept;
  logic [31:0] out_reg;
  logic [31:0] sync1, sync2;
  logic [31:0] cycle_cnt;
  logic        overflow;
  logic [31:0] rdata_next;
  logic [31:0] status_word;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [4:0]       count;
  logic             fifo_full, fifo_empty;
  logic             push_req, push, pop;

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) state <= IDLE;
    else                    state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbg_state = (state == RESP);
  assign accept    = req_valid && req_ready;

  assign fifo_empty = (count == 5'd0);
  assign fifo_full  = (count == DEPTH_C);
  assign tx_valid   = !fifo_empty;
  assign tx_data    = tx_valid ? fifo_mem[rd_ptr] : 32'd0;
  assign pop        = tx_valid && tx_ready;
  assign push_req   = accept && req_we && (req_addr == ADDR_TXPUSH);
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign push       = push_req && (!fifo_full || pop);

  assign status_word = {15'd0, overflow, 6'd0, fifo_full, fifo_empty, 3'd0, count};

  always_comb begin
    rdata_next = 32'hDEADBEEF;
    case (req_addr)
      ADDR_OUT:    rdata_next = out_reg;
      ADDR_IN:     rdata_next = sync2;
      ADDR_TXPUSH: rdata_next = 32'd0;
      ADDR_STATUS: rdata_next = status_word;
      ADDR_CYCLE:  rdata_next = cycle_cnt;
      default:     rdata_next = 32'hDEADBEEF;
    endcase
    if (req_we) rdata_next = 32'd0;
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      resp_rdata <= 32'd0;
      out_reg    <= 32'd0;
      sync1      <= 32'd0;
      sync2      <= 32'd0;
      cycle_cnt  <= 32'd0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= 5'd0;
    end else begin
      sync1     <= meminput;
      sync2     <= sync1;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (accept) resp_rdata <= rdata_next;
      if (accept && req_we && (req_addr == ADDR_OUT)) begin
        for (int b = 0; b < 4; b++) begin
          if (req_wmask[b]) out_reg[8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
      if (accept && req_we && (req_addr == ADDR_STATUS) && req_wmask[2] && req_wdata[16])
        overflow <= 1'b0;
      else if (push_req && !push)
        overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + 5'd1;
      else if (pop && !push) count <= count - 5'd1;
    end
  end

  // Storage needs no reset: tx_data is masked to zero while the FIFO is empty.
  always_ff @(posedge clkrst_core_clk) begin
    if (push) fifo_mem[wr_ptr] <= req_wdata;
  end

  assign memoutput = out_reg;

endmodule

// File: tb/tb_mcpu_mmio_port.sv
// Bench for mcpu_mmio_port: directed scenarios plus randomized traffic, checked against a
// transaction-level model through an expected-response queue.
module tb_mcpu_mmio_port;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_addr = 3'd0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wmask = 4'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [31:0] memoutput;
  logic [31:0] meminput = 32'd0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic        dbg_state;

  mcpu_mmio_port #(.FIFO_DEPTH(DEPTH)) dut (
    .clkrst_core_clk  (clk),
    .clkrst_core_rst_n(rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_we           (req_we),
    .req_wdata        (req_wdata),
    .req_wmask        (req_wmask),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .memoutput        (memoutput),
    .meminput         (meminput),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_data          (tx_data),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- reference model state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] m_fifo[$];
  logic [31:0] m_out, m_s1, m_s2, m_cycle, m_rd;
  logic        m_ovf, m_pending, m_pop, m_preq;
  int          m_cnt;
  int          rr_mode = 2;   // 0 random, 1 hold low, 2 hold high
  int          tx_mode = 0;   // 0 low, 1 high, 2 random
  bit          rand_in = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, register map as documented,
  // FIFO as a queue, IN as meminput delayed by two edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_fifo.delete();
      m_out = 0; m_s1 = 0; m_s2 = 0; m_cycle = 0; m_ovf = 0; m_pending = 0;
    end else begin
      m_cnt  = m_fifo.size();
      m_pop  = (m_cnt != 0) && tx_ready;
      m_preq = 1'b0;
      if (!m_pending && req_valid) begin
        case (req_addr)
          3'd0: m_rd = m_out;
          3'd1: m_rd = m_s2;
          3'd2: m_rd = 32'd0;
          3'd3: m_rd = {15'd0, m_ovf, 6'd0, (m_cnt == DEPTH), (m_cnt == 0), 3'd0, 5'(m_cnt)};
          3'd4: m_rd = m_cycle;
          default: m_rd = 32'hDEADBEEF;
        endcase
        if (req_we) begin
          m_rd = 32'd0;
          if (req_addr == 3'd0)
            for (int b = 0; b < 4; b++) if (req_wmask[b]) m_out[8*b +: 8] = req_wdata[8*b +: 8];
          if (req_addr == 3'd2) m_preq = 1'b1;
          if (req_addr == 3'd3 && req_wmask[2] && req_wdata[16]) m_ovf = 1'b0;
        end
        exp_q.push_back(m_rd);
        m_pending = 1'b1;
      end else if (m_pending && resp_ready) begin
        m_pending = 1'b0;
      end
      if (m_pop) void'(m_fifo.pop_front());
      if (m_preq) begin
        if (m_cnt < DEPTH || m_pop) m_fifo.push_back(req_wdata);
        else m_ovf = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = meminput;
      m_cycle = m_cycle + 32'd1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", req_ready, !m_pending);
      check("resp_valid", resp_valid, m_pending);
      check("memoutput", memoutput, m_out);
      check("tx_valid", tx_valid, m_fifo.size() != 0);
      check("tx_data", tx_data, (m_fifo.size() != 0) ? m_fifo[0] : 32'd0);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp_unexpected actual=%08h required=none t=%0t", resp_rdata, $time);
        end else begin
          check("resp_rdata", resp_rdata, exp_q[0]);
          if (resp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- background drivers ----------------
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0: resp_ready = 1'($urandom_range(0, 1));
      1: resp_ready = 1'b0;
      default: resp_ready = 1'b1;
    endcase
    case (tx_mode)
      0: tx_ready = 1'b0;
      1: tx_ready = 1'b1;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    if (rand_in && $urandom_range(0, 3) == 0) meminput = $urandom;
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_req(input logic [2:0] a, input logic we, input logic [31:0] d, input logic [3:0] m);
    int n = 0;
    while (m_pending && n < 100) begin @(posedge clk); #1; n++; end
    if (m_pending) begin
      checks++; failures++;
      $display("FAIL req_wait actual=pending required=idle t=%0t", $time);
    end
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = d; req_wmask = m;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_memoutput", memoutput, 32'd0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 32'd0);

    rst_n = 1'b1;
    do_req(3'd4, 1'b0, 32'd0, 4'd0);                  // accepted on the first edge

    do_req(3'd0, 1'b1, 32'h12345678, 4'b1111);
    do_req(3'd0, 1'b1, 32'hFFFFFFFF, 4'b0010);
    check("out_masked", memoutput, 32'h1234FF78);
    do_req(3'd0, 1'b0, 32'd0, 4'd0);

    meminput = 32'd5;
    wait_cycles(2);
    do_req(3'd1, 1'b0, 32'd0, 4'd0);
    meminput = 32'd9;
    do_req(3'd1, 1'b0, 32'd0, 4'd0);                  // still the old value
    wait_cycles(3);
    do_req(3'd1, 1'b0, 32'd0, 4'd0);

    for (int i = 0; i < 5; i++) do_req(3'd2, 1'b1, 32'hA + 32'(i), 4'd0);
    do_req(3'd3, 1'b0, 32'd0, 4'd0);
    tx_mode = 1; tx_ready = 1'b1;
    wait_cycles(6);
    tx_mode = 0; tx_ready = 1'b0;
    do_req(3'd3, 1'b1, 32'h00010000, 4'b0100);
    do_req(3'd3, 1'b0, 32'd0, 4'd0);

    for (int i = 0; i < 4; i++) do_req(3'd2, 1'b1, 32'h100 + 32'(i), 4'd0);
    tx_mode = 1; tx_ready = 1'b1;
    do_req(3'd2, 1'b1, 32'h55, 4'd0);
    tx_mode = 0; tx_ready = 1'b0;
    do_req(3'd3, 1'b0, 32'd0, 4'd0);
    do_req(3'd6, 1'b0, 32'd0, 4'd0);
    do_req(3'd5, 1'b1, 32'h1234, 4'hF);
    do_req(3'd4, 1'b1, 32'h0, 4'hF);
    tx_mode = 1; tx_ready = 1'b1;
    wait_cycles(6);

    rr_mode = 1; resp_ready = 1'b0;
    do_req(3'd4, 1'b0, 32'd0, 4'd0);
    wait_cycles(5);
    rr_mode = 2; resp_ready = 1'b1;
    do_req(3'd0, 1'b0, 32'd0, 4'd0);

    rr_mode = 0; tx_mode = 2; rand_in = 1'b1;
    for (int i = 0; i < 300; i++)
      do_req(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));

    rr_mode = 1; resp_ready = 1'b0; rand_in = 1'b0;
    wait_cycles(30);
    rr_mode = 2; resp_ready = 1'b1;
    wait_cycles(2);
    rr_mode = 1; resp_ready = 1'b0;
    do_req(3'd0, 1'b1, 32'hCAFEF00D, 4'hF);
    wait_cycles(1);
    rst_n = 1'b0;
    #1;
    check("rst_resp_drop", resp_valid, 1'b0);
    check("rst_out_clear", memoutput, 32'd0);
    check("rst_req_ready2", req_ready, 1'b1);
    check("rst_tx_clear", tx_valid, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; rr_mode = 2; resp_ready = 1'b1; tx_mode = 0; tx_ready = 1'b0;
    wait_cycles(3);
    do_req(3'd4, 1'b0, 32'd0, 4'd0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
